// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store sequencer between the core MEM stage and a word-only
// data memory (asynchronous word read, synchronous word write).
//
// Adds RISC-V byte/halfword support on top of the word memory:
//   * LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through
//   * SB/SH are done as read-modify-write of the containing word
//   * misaligned accesses and illegal width codes complete with resp_err=1
//     and never touch memory
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready core request handshake (ready only in IDLE)
//   req_we          1=store, 0=load
//   req_funct3      RISC-V width code
//   req_addr        byte address
//   req_wdata       store data (low byte/half used for SB/SH)
//   resp_valid      one-cycle completion pulse
//   resp_rdata      extended load data (0 for stores/errors)
//   resp_err        misaligned or illegal funct3, qualified by resp_valid
//   mem_rd_en       memory read enable
//   mem_wr_en       memory write enable (forced low while rst=1)
//   mem_addr        word-aligned address, 0 in IDLE
//   mem_wr_data     full word to write
//   mem_rd_data     asynchronous memory read data
//
// Latency from accept cycle T to resp_valid: loads/SW/errors T+2, SB/SH T+3.

module lsu_ctrl #(
    parameter int WIDTH    = 32,
    parameter int ADDR_LSB = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wr_data,
    input  logic [WIDTH-1:0] mem_rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        LD,
        RMW_RD,
        WR,
        ERR,
        RESP
    } state_t;

    state_t state_q, state_d;

    // Latched request
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;

    // Merged store word for SB/SH and registered response
    logic [WIDTH-1:0] merge_q;
    logic [WIDTH-1:0] rdata_q;
    logic             err_q;

    logic [WIDTH-1:0] word_addr;

    assign word_addr = {addr_q[WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};

    // True when the request must complete as an error without memory access.
    function automatic logic req_bad(input logic       we,
                                     input logic [2:0] f3,
                                     input logic [1:0] lane);
        logic illegal;
        logic misaligned;
        if (we)
            illegal = f3[2] || (f3 == 3'b011);
        else
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        misaligned = ((f3[1:0] == 2'b01) && lane[0]) ||
                     ((f3[1:0] == 2'b10) && (lane != 2'b00));
        return illegal || misaligned;
    endfunction

    // Lane select plus sign/zero extension of a load.
    function automatic logic [WIDTH-1:0] load_extend(input logic [WIDTH-1:0] word,
                                                     input logic [2:0]       f3,
                                                     input logic [1:0]       lane);
        logic [7:0]       b;
        logic [15:0]      h;
        logic [WIDTH-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{(WIDTH-8){b[7]}}, b};
            3'b100:  r = {{(WIDTH-8){1'b0}}, b};
            3'b001:  r = {{(WIDTH-16){h[15]}}, h};
            3'b101:  r = {{(WIDTH-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte (SB) or halfword (SH) of the read word.
    function automatic logic [WIDTH-1:0] store_merge(input logic [WIDTH-1:0] word,
                                                     input logic [WIDTH-1:0] wd,
                                                     input logic [2:0]       f3,
                                                     input logic [1:0]       lane);
        logic [WIDTH-1:0] r;
        r = word;
        if (f3[1:0] == 2'b00)
            r[{lane, 3'b000} +: 8] = wd[7:0];
        else
            r[{lane[1], 4'b0000} +: 16] = wd[15:0];
        return r;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Request latch, merge word and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                    end
                end
                LD: begin
                    rdata_q <= load_extend(mem_rd_data, funct3_q, addr_q[1:0]);
                end
                RMW_RD: begin
                    merge_q <= store_merge(mem_rd_data, wdata_q, funct3_q, addr_q[1:0]);
                end
                WR: begin
                    rdata_q <= '0;
                end
                ERR: begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
                RESP: begin
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Next state and memory/handshake outputs
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;

        case (state_q)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    if (req_bad(req_we, req_funct3, req_addr[1:0]))
                        state_d = ERR;
                    else if (!req_we)
                        state_d = LD;
                    else if (req_funct3[1:0] == 2'b10)
                        state_d = WR;
                    else
                        state_d = RMW_RD;
                end
            end
            LD: begin
                mem_rd_en = 1'b1;
                mem_addr  = word_addr;
                state_d   = RESP;
            end
            RMW_RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = word_addr;
                state_d   = WR;
            end
            WR: begin
                // Gating by rst guarantees an abandoned store never lands.
                mem_wr_en   = !rst;
                mem_addr    = word_addr;
                mem_wr_data = (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;
                state_d     = RESP;
            end
            ERR: begin
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // we_q is kept for debug visibility of the accepted request direction.
    logic unused_ok;
    assign unused_ok = we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a 256-word behavioural memory.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic [31:0] tb_mem [0:255];

    int checks = 0;
    int fails  = 0;

    lsu_ctrl #(.WIDTH(32), .ADDR_LSB(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = tb_mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_wr_en)
            tb_mem[mem_addr[9:2]] <= mem_wr_data;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;   // cycle after accept where the write shows, -1 = none
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_req(input vec_t v, input int idx);
        int  k;
        int  wr_at;
        int  wr_cnt;
        bit  got;
        string nm;
        nm = $sformatf("vec%0d", idx);
        wait_ready(nm);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        k = 0; got = 0; wr_at = -1; wr_cnt = 0;
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            if (k == 1) req_valid = 1'b0;
            if (mem_wr_en) begin
                wr_cnt++;
                if (wr_at < 0) wr_at = k;
            end
            if (resp_valid) got = 1;
        end
        chk({nm, "_resp_seen"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, 32'(k), 32'(v.exp_lat));
        chk({nm, "_rdata"}, resp_rdata, v.exp_rdata);
        chk({nm, "_err"}, 32'(resp_err), 32'(v.exp_err));
        chk({nm, "_wr_cycle"}, 32'(wr_at), 32'(v.exp_wr));
        chk({nm, "_wr_count"}, 32'(wr_cnt), (v.exp_wr >= 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          nresp;
        int          last_acc;
        int          pulses;
        logic [31:0] expq [$];

        //            we    f3      addr    wdata          rdata          err  lat wr
        tbl[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 2,  1};
        tbl[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, -1};
        tbl[2]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 2, -1};
        tbl[3]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0, 2, -1};
        tbl[4]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 2, -1};
        tbl[5]  = '{1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 2, -1};
        tbl[6]  = '{1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 32'h00000000, 1'b0, 3,  2};
        tbl[7]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 2, -1};
        tbl[8]  = '{1'b1, 3'b001, 32'h12, 32'hABCD1234, 32'h00000000, 1'b0, 3,  2};
        tbl[9]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 1'b0, 2, -1};
        tbl[10] = '{1'b0, 3'b010, 32'h12, 32'h0,        32'h00000000, 1'b1, 2, -1};
        tbl[11] = '{1'b1, 3'b001, 32'h11, 32'h0000FFFF, 32'h00000000, 1'b1, 2, -1};
        tbl[12] = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h00000000, 1'b1, 2, -1};
        tbl[13] = '{1'b1, 3'b100, 32'h10, 32'h11111111, 32'h00000000, 1'b1, 2, -1};
        tbl[14] = '{1'b0, 3'b110, 32'h10, 32'h0,        32'h00000000, 1'b1, 2, -1};
        tbl[15] = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 1'b0, 2, -1};
        tbl[16] = '{1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 2, -1};
        tbl[17] = '{1'b0, 3'b001, 32'h10, 32'h0,        32'h000055EF, 1'b0, 2, -1};
        tbl[18] = '{1'b0, 3'b100, 32'h11, 32'h0,        32'h00000055, 1'b0, 2, -1};
        tbl[19] = '{1'b1, 3'b000, 32'h13, 32'h00000080, 32'h00000000, 1'b0, 3,  2};
        tbl[20] = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2, -1};

        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        // Reset behaviour
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_rst_resp_rdata", resp_rdata, 32'h0);
        chk("post_rst_resp_err", 32'(resp_err), 32'd0);
        chk("post_rst_mem_addr", mem_addr, 32'h0);

        // Table-driven single transactions
        for (int i = 0; i < NVEC; i++) run_req(tbl[i], i);
        chk("mem_word_0x10", tb_mem[4], 32'h803455EF);

        // Reset asserted while an SB sits in its write state
        wait_ready("abort");
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h12;
        req_wdata  = 32'h00000011;
        @(negedge clk);                 // RMW read cycle
        req_valid = 1'b0;
        @(negedge clk);                 // write cycle
        chk("abort_wr_before_rst", 32'(mem_wr_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_wr_gated", 32'(mem_wr_en), 32'd0);
        chk("abort_ready_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        chk("abort_no_resp", 32'(pulses), 32'd0);
        chk("abort_mem_kept", tb_mem[4], 32'h803455EF);

        // req_valid held high with alternating SW/LW
        n = 0; nresp = 0; last_acc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                nresp++;
                if (expq.size() == 0)
                    chk("b2b_unexpected_resp", 32'(nresp), 32'd0);
                else
                    chk($sformatf("b2b_rdata%0d", nresp), resp_rdata, expq.pop_front());
            end
            if (req_ready) begin
                if (n < 6) begin
                    req_valid  = 1'b1;
                    req_we     = (n % 2 == 0);
                    req_funct3 = 3'b010;
                    req_addr   = 32'h20;
                    req_wdata  = 32'hA0000000 + 32'(n / 2);
                    if (n > 0) chk($sformatf("b2b_gap%0d", n), 32'(cyc - last_acc), 32'd3);
                    last_acc = cyc;
                    expq.push_back((n % 2 == 0) ? 32'h0 : 32'hA0000000 + 32'(n / 2));
                    n++;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepted", 32'(n), 32'd6);
        chk("b2b_responses", 32'(nresp), 32'd6);
        chk("b2b_mem_word", tb_mem[8], 32'hA0000002);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
